// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for a shared single-port RAM
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       last_d;
  logic       grant_d;
  logic [3:0] cnt;
  logic       pick_d;
  logic       unused;

  // On a tie the port that did not win last time is chosen.
  assign pick_d = d_req & (~i_req | ~last_d);
  assign unused = &{1'b0, d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      grant_d   <= 1'b0;
      cnt       <= 4'd0;
      i_ack     <= 1'b0;
      i_data    <= 32'd0;
      d_ack     <= 1'b0;
      d_rdata   <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 4'd0;
      mem_addr  <= 30'd0;
      mem_wdata <= 32'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d <= pick_d;
            last_d  <= pick_d;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr[31:2];
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 4'd0;
              mem_addr  <= i_addr;
              mem_wdata <= 32'd0;
            end
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 4'd0;
          mem_addr  <= 30'd0;
          mem_wdata <= 32'd0;
          cnt       <= 4'(MEM_LAT - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (grant_d) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_data <= mem_rdata;
              i_ack  <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT 1 and 3
module tb_mem_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    bit          chk_w;
    int          cyc;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        i_req [2];
  logic [29:0] i_addr [2];
  logic        i_ack [2];
  logic [31:0] i_data [2];
  logic        d_req [2];
  logic [3:0]  d_we [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        d_ack [2];
  logic [31:0] d_rdata [2];
  logic        mem_en [2];
  logic [3:0]  mem_we [2];
  logic [29:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy [2];

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  ack_t ack_q [2][$];
  acc_t acc_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_data(i_data[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_data(i_data[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  function automatic logic [31:0] word(input logic [29:0] a);
    if (a == 30'h10) return 32'h00500093;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // RAM models: read data is only meaningful in the single cycle it is due.
  logic        v1 = 1'b0;
  logic [29:0] a1 = 30'd0;
  logic        vp [3] = '{1'b0, 1'b0, 1'b0};
  logic [29:0] ap [3] = '{30'd0, 30'd0, 30'd0};

  always @(posedge clk) begin
    v1 <= mem_en[0];
    a1 <= mem_addr[0];
    vp[0] <= mem_en[1];
    ap[0] <= mem_addr[1];
    vp[1] <= vp[0];
    ap[1] <= ap[0];
    vp[2] <= vp[1];
    ap[2] <= ap[1];
  end

  assign mem_rdata[0] = v1 ? word(a1) : 32'hBAD0_0001;
  assign mem_rdata[1] = vp[2] ? word(ap[2]) : 32'hBAD0_0003;

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, n, cyc, act, exp);
    end
  endtask

  task automatic push_ack(input int n, input bit is_d, input logic [31:0] data, input bit c, input int cy);
    ack_t e;
    e.is_d = is_d;
    e.data = data;
    e.chk_data = c;
    e.cyc = cy;
    ack_q[n].push_back(e);
  endtask

  task automatic push_acc(input int n, input logic [29:0] addr, input logic [3:0] we,
                          input logic [31:0] wdata, input bit c, input int cy);
    acc_t m;
    m.addr = addr;
    m.we = we;
    m.wdata = wdata;
    m.chk_w = c;
    m.cyc = cy;
    acc_q[n].push_back(m);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int n);
    chk("rst_i_ack", n, 32'(i_ack[n]), 32'd0);
    chk("rst_d_ack", n, 32'(d_ack[n]), 32'd0);
    chk("rst_mem_en", n, 32'(mem_en[n]), 32'd0);
    chk("rst_mem_we", n, 32'(mem_we[n]), 32'd0);
    chk("rst_mem_addr", n, 32'(mem_addr[n]), 32'd0);
    chk("rst_mem_wdata", n, mem_wdata[n], 32'd0);
    chk("rst_busy", n, 32'(busy[n]), 32'd0);
    chk("rst_i_data", n, i_data[n], 32'd0);
    chk("rst_d_rdata", n, d_rdata[n], 32'd0);
  endtask

  ack_t me;
  acc_t mm;

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (i_ack[n] || d_ack[n]) begin
        chk("ack_overlap", n, 32'(i_ack[n] & d_ack[n]), 32'd0);
        if (ack_q[n].size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spurious_ack dut%0d cycle %0d: got ack, expected none", n, cyc);
        end else begin
          me = ack_q[n].pop_front();
          chk("ack_port_is_d", n, 32'(d_ack[n]), 32'(me.is_d));
          chk("ack_cycle", n, 32'(cyc), 32'(me.cyc));
          if (me.chk_data) chk("ack_data", n, d_ack[n] ? d_rdata[n] : i_data[n], me.data);
        end
      end
      if (mem_en[n]) begin
        if (acc_q[n].size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spurious_mem_en dut%0d cycle %0d: got access %h, expected none", n, cyc, mem_addr[n]);
        end else begin
          mm = acc_q[n].pop_front();
          chk("mem_cycle", n, 32'(cyc), 32'(mm.cyc));
          chk("mem_addr", n, 32'(mem_addr[n]), 32'(mm.addr));
          chk("mem_we", n, 32'(mem_we[n]), 32'(mm.we));
          if (mm.chk_w) chk("mem_wdata", n, mem_wdata[n], mm.wdata);
        end
      end else begin
        chk("idle_mem_we", n, 32'(mem_we[n]), 32'd0);
      end
    end
  end

  initial begin
    int t;
    for (int n = 0; n < 2; n++) begin
      rst[n] = 1'b1;
      i_req[n] = 1'b0;
      i_addr[n] = 30'd0;
      d_req[n] = 1'b0;
      d_we[n] = 4'd0;
      d_addr[n] = 32'd0;
      d_wdata[n] = 32'd0;
    end
    step(2);
    check_zero(0);
    check_zero(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step(2);

    // Single fetch, MEM_LAT=1, with busy profile.
    t = cyc;
    i_addr[0] = 30'h10;
    i_req[0] = 1'b1;
    push_acc(0, 30'h10, 4'd0, 32'd0, 1'b0, t + 1);
    push_ack(0, 1'b0, 32'h00500093, 1'b1, t + 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("busy", 0, 32'(busy[0]), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        @(posedge clk);
        #1;
        i_req[0] = 1'b0;
      end
    end
    step(1);

    // Back-to-back fetch: new address presented the cycle after ack.
    t = cyc;
    i_addr[0] = 30'h20;
    i_req[0] = 1'b1;
    push_acc(0, 30'h20, 4'd0, 32'd0, 1'b0, t + 1);
    push_ack(0, 1'b0, word(30'h20), 1'b1, t + 3);
    step(4);
    i_addr[0] = 30'h21;
    push_acc(0, 30'h21, 4'd0, 32'd0, 1'b0, t + 5);
    push_ack(0, 1'b0, word(30'h21), 1'b1, t + 7);
    step(4);
    i_req[0] = 1'b0;
    step(1);

    // Byte-enabled store.
    t = cyc;
    d_addr[0] = 32'h00000106;
    d_we[0] = 4'b1100;
    d_wdata[0] = 32'hABCD0000;
    d_req[0] = 1'b1;
    push_acc(0, 30'h41, 4'b1100, 32'hABCD0000, 1'b1, t + 1);
    push_ack(0, 1'b1, 32'd0, 1'b0, t + 3);
    step(4);
    d_req[0] = 1'b0;
    d_we[0] = 4'd0;
    step(1);

    // Both requesters held from reset: fetch first, then strict alternation.
    rst[0] = 1'b1;
    i_addr[0] = 30'h30;
    d_addr[0] = 32'h00000200;
    i_req[0] = 1'b1;
    d_req[0] = 1'b1;
    step(1);
    rst[0] = 1'b0;
    t = cyc;
    push_acc(0, 30'h30, 4'd0, 32'd0, 1'b0, t + 1);
    push_ack(0, 1'b0, word(30'h30), 1'b1, t + 3);
    push_acc(0, 30'h80, 4'd0, 32'd0, 1'b0, t + 5);
    push_ack(0, 1'b1, word(30'h80), 1'b1, t + 7);
    push_acc(0, 30'h30, 4'd0, 32'd0, 1'b0, t + 9);
    push_ack(0, 1'b0, word(30'h30), 1'b1, t + 11);
    push_acc(0, 30'h80, 4'd0, 32'd0, 1'b0, t + 13);
    push_ack(0, 1'b1, word(30'h80), 1'b1, t + 15);
    step(16);
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
    step(1);

    // MEM_LAT=3: data read, fetch arriving mid-transaction waits.
    t = cyc;
    d_addr[1] = 32'h00000040;
    d_req[1] = 1'b1;
    push_acc(1, 30'h10, 4'd0, 32'd0, 1'b0, t + 1);
    push_ack(1, 1'b1, 32'h00500093, 1'b1, t + 5);
    step(2);
    i_addr[1] = 30'h30;
    i_req[1] = 1'b1;
    push_acc(1, 30'h30, 4'd0, 32'd0, 1'b0, t + 7);
    push_ack(1, 1'b0, word(30'h30), 1'b1, t + 11);
    step(4);
    d_req[1] = 1'b0;
    step(6);
    i_req[1] = 1'b0;
    step(1);

    // Reset during WAIT aborts silently; next tie goes to fetch.
    t = cyc;
    i_addr[1] = 30'h44;
    i_req[1] = 1'b1;
    push_acc(1, 30'h44, 4'd0, 32'd0, 1'b0, t + 1);
    step(3);
    rst[1] = 1'b1;
    i_req[1] = 1'b0;
    #1;
    check_zero(1);
    i_addr[1] = 30'h50;
    d_addr[1] = 32'h00000600;
    i_req[1] = 1'b1;
    d_req[1] = 1'b1;
    step(3);
    rst[1] = 1'b0;
    t = cyc;
    push_acc(1, 30'h50, 4'd0, 32'd0, 1'b0, t + 1);
    push_ack(1, 1'b0, word(30'h50), 1'b1, t + 5);
    push_acc(1, 30'h180, 4'd0, 32'd0, 1'b0, t + 7);
    push_ack(1, 1'b1, word(30'h180), 1'b1, t + 11);
    step(6);
    i_req[1] = 1'b0;
    step(6);
    d_req[1] = 1'b0;
    step(4);

    for (int n = 0; n < 2; n++) begin
      chk("ack_q_drained", n, 32'(ack_q[n].size()), 32'd0);
      chk("acc_q_drained", n, 32'(acc_q[n].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
